pic_window_reader: RTL
======================

# pic_window_reader

Consumes the 10-bit horizontal window position (Xaddr, 0..639) produced by the picture-position tester stage and turns it into SDRAM burst read requests for a WIN_W-pixel-wide window, one display line at a time. The position is sampled only at frame start, so the window never tears mid-frame. The requests go to the SDRAM controller read port through a req/ack handshake. The block is paced by the display timing's frame_start and line_start pulses.

## Interface
- H_RES, 640, pixels per stored line (address stride)
- V_RES, 480, lines per frame
- WIN_W, 128, window width in pixels; must be a multiple of BURST
- BURST, 32, words per read request
- AW, 23, SDRAM word-address width
- BASE_ADDR, 0, frame-buffer base word address
- SLEW_STEP, 8, max x change per frame (only used with slew enabled)

- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- Xaddr  input  10  requested window left edge
- frame_start  input  1  one-cycle pulse at start of frame
- line_start  input  1  one-cycle pulse at start of each line fetch slot
- rd_req  output  1  read request; held until acked
- rd_addr  output  AW  burst start word address; stable while rd_req=1
- rd_ack  input  1  controller accepts the request in the cycle it is high with rd_req=1
- x_cur  output  10  window left edge in use this frame
- busy  output  1  high in any state other than S_IDLE
- frame_done  output  1  one-cycle pulse after the last request of a frame is acked
- overrun  output  1  sticky; line_start arrived while the previous line's requests were still in progress

## Operation
- Clamp: tgt = min(Xaddr, H_RES-WIN_W). For example, 522 becomes 512 and 10 stays 10.
- At frame_start, x_cur is updated from tgt (directly, or slewed; see Configuration). The row base is reset to BASE_ADDR, and the line and burst counters are cleared.
- State S_IDLE: wait for frame_start, then go to S_WAIT_LINE.
- State S_WAIT_LINE: wait for line_start, then go to S_REQ.
- State S_REQ: rd_req=1 with rd_addr = row_base + x_cur + k*BURST, for k = 0..WIN_W/BURST-1. On rd_ack, go to S_NEXT.
- State S_NEXT: rd_req=0. Increment k.
  - If k < WIN_W/BURST, go to S_REQ.
  - Otherwise, set k=0, row_base += H_RES, line += 1.
  - If line < V_RES, go to S_WAIT_LINE. Otherwise pulse frame_done and go to S_IDLE.
- Arithmetic:
  - row_base is accumulated by adding H_RES each line; no multiplier.
  - All address sums are AW bits wide and wrap modulo 2^AW.
  - The line counter is 10 bits wide.
- Boundary and simultaneous-event rules:
  - frame_start in S_WAIT_LINE or S_NEXT: restart immediately (re-latch x, clear counters, go to S_WAIT_LINE).
  - frame_start in S_REQ: set restart_pending. The outstanding request completes on rd_ack, then the block restarts without issuing further bursts. rd_req never drops without an ack.
  - frame_start and line_start in the same cycle: frame_start wins and line_start is ignored.
  - line_start in S_REQ or S_NEXT: set overrun. The pulse is otherwise ignored, so that line slot is lost. overrun clears on frame_start.
  - line_start in S_IDLE is ignored.
  - Xaddr changes mid-frame have no effect until the next frame_start.
- Reset values: state S_IDLE, rd_req 0, rd_addr 0, x_cur 0, busy 0, frame_done 0, overrun 0, counters 0. Reset mid-handshake drops rd_req asynchronously.

## Timing
- line_start at cycle n gives rd_req=1 at n+1.
- rd_ack at cycle m gives rd_req=0 at m+1, and the next burst's rd_req=1 at m+2.
- frame_done is high in the cycle after the final ack, together with the return to S_IDLE.
- x_cur updates in the cycle after frame_start.
- rd_ack is accepted in the same cycle rd_req is first raised; zero-wait acks are legal.
- All outputs are registered.

## Configuration
- PICWIN_SLEW_EN defined: at each frame_start, x_cur moves toward tgt by min(|tgt-x_cur|, SLEW_STEP). This gives smooth panning between tester positions.
- PICWIN_SLEW_EN undefined: x_cur = tgt at each frame_start, and SLEW_STEP is unused.

## Structure
- Shared package pic_pkg holds:
  - H_RES, V_RES and WIN_W defaults;
  - the state enum (S_IDLE, S_WAIT_LINE, S_REQ, S_NEXT);
  - the 10-bit x coordinate type.
- Sub-module pic_x_slew contains the clamp and the optional slew. It is clocked with clk and rst_n, enabled by frame_start, and outputs x_cur.

## Test plan
- Clamp: Xaddr=522, frame_start, line_start, immediate acks. Expect rd_addr 512, 544, 576, 608 on line 0, then 1152 on line 1 (BASE_ADDR=0).
- Stall: Xaddr=266, hold rd_ack low for 5 cycles. rd_req and rd_addr=266 stay stable throughout; after the ack, the next request is 298 two cycles later.
- Full frame: V_RES=4 and immediate acks. Exactly 16 acks, then frame_done pulses once, then busy=0.
- Mid-frame restart: frame_start during S_REQ with the ack delayed by 3 cycles. The pending request completes, no further burst of the old frame is issued, and the next request is line 0 at the new x.
- Overrun: line_start pulsed while in S_REQ. overrun=1, stays set until the next frame_start, then reads 0.
- With PICWIN_SLEW_EN: reset, Xaddr=266. x_cur reads 8, 16, 24 after three frame_starts; Xaddr=10 at x_cur=24 gives 16, then 10.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the picture-window reader: geometry defaults, FSM states, x type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pic_pkg;

  localparam int PIC_H_RES = 640;
  localparam int PIC_V_RES = 480;
  localparam int PIC_WIN_W = 128;

  // Horizontal pixel coordinate of the window left edge.
  typedef logic [9:0] pic_x_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LINE = 2'd1,
    S_REQ       = 2'd2,
    S_NEXT      = 2'd3
  } pic_state_e;

endpackage

// File: rtl/pic_x_slew.sv
// Clamps the requested window edge to the frame and latches it (optionally slewed) at frame start.
// Latency: x_cur_o updates one cycle after en_i; PICWIN_SLEW_EN limits each step to SLEW_STEP.
// Backpressure: none; en_i is a single-cycle strobe and is always accepted.
module pic_x_slew
  import pic_pkg::*;
#(
  parameter int H_RES     = PIC_H_RES,
  parameter int WIN_W     = PIC_WIN_W,
  parameter int SLEW_STEP = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  pic_x_t xaddr_i,
  output pic_x_t x_cur_o
);

  // Right-most legal left edge: the whole window must stay inside the line.
  localparam pic_x_t X_MAX = pic_x_t'(H_RES - WIN_W);

  pic_x_t tgt;
  pic_x_t x_q;
  pic_x_t x_d;

`ifdef PICWIN_SLEW_EN
  localparam pic_x_t STEP = pic_x_t'(SLEW_STEP);
  pic_x_t diff;

  // Clamp, then move at most STEP toward the target at each frame start.
  always_comb begin
    tgt  = (xaddr_i > X_MAX) ? X_MAX : xaddr_i;
    x_d  = x_q;
    diff = '0;
    if (en_i) begin
      if (tgt >= x_q) begin
        diff = tgt - x_q;
        x_d  = x_q + ((diff > STEP) ? STEP : diff);
      end else begin
        diff = x_q - tgt;
        x_d  = x_q - ((diff > STEP) ? STEP : diff);
      end
    end
  end
`else
  // Clamp and jump straight to the target at each frame start.
  always_comb begin
    tgt = (xaddr_i > X_MAX) ? X_MAX : xaddr_i;
    x_d = en_i ? tgt : x_q;
  end
`endif

  // Window edge register; only changes on frame start so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
    end else begin
      x_q <= x_d;
    end
  end

  assign x_cur_o = x_q;

endmodule

// File: rtl/pic_window_reader.sv
// Turns the per-frame window edge into per-line SDRAM burst read requests (WIN_W/BURST bursts per line).
// Latency: line_start -> rd_req one cycle; ack -> next rd_req two cycles; final ack -> frame_done next cycle.
// Backpressure: rd_req/rd_addr are held until rd_ack; slow acks cost line slots (flagged by sticky overrun). Option macro: PICWIN_SLEW_EN.
module pic_window_reader
  import pic_pkg::*;
#(
  parameter int H_RES     = PIC_H_RES,
  parameter int V_RES     = PIC_V_RES,
  parameter int WIN_W     = PIC_WIN_W,
  parameter int BURST     = 32,
  parameter int AW        = 23,
  parameter int BASE_ADDR = 0,
  parameter int SLEW_STEP = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    Xaddr,
  input  logic          frame_start,
  input  logic          line_start,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_ack,
  output logic [9:0]    x_cur,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  localparam int            NB         = WIN_W / BURST;
  localparam int            KW         = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(NB - 1);
  localparam logic [9:0]    LINE_LAST  = 10'(V_RES - 1);
  localparam logic [AW-1:0] BASE       = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(H_RES);
  localparam logic [AW-1:0] BURST_A    = AW'(BURST);

  pic_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [9:0]    line_q, line_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic          restart_q, restart_d;
  logic          busy_q;
  logic          restart_now;
  logic          ack;
  logic [AW-1:0] burst_addr;
  pic_x_t        x_cur_w;

  pic_x_slew #(
    .H_RES     (H_RES),
    .WIN_W     (WIN_W),
    .SLEW_STEP (SLEW_STEP)
  ) u_x_slew (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (frame_start),
    .xaddr_i (Xaddr),
    .x_cur_o (x_cur_w)
  );

  assign ack        = rd_req_q & rd_ack;
  // Constant multiply by BURST; wraps modulo 2^AW like every other address sum.
  assign burst_addr = row_base_q + AW'(x_cur_w) + (AW'(k_q) * BURST_A);

  // Next-state, counters and registered-output values for the line/burst sequencer.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    line_d       = line_q;
    row_base_d   = row_base_q;
    rd_req_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    restart_d    = restart_q;
    restart_now  = 1'b0;

    // A line slot that arrives while the previous line is still fetching is lost.
    if (line_start && !frame_start && (state_q == S_REQ || state_q == S_NEXT)) begin
      overrun_d = 1'b1;
    end
    if (frame_start) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) restart_now = 1'b1;
      end
      S_WAIT_LINE: begin
        if (frame_start) begin
          restart_now = 1'b1;
        end else if (line_start) begin
          state_d   = S_REQ;
          rd_req_d  = 1'b1;
          rd_addr_d = burst_addr;
        end
      end
      S_REQ: begin
        // Never withdraw an un-acked request; a frame restart waits for the ack.
        rd_req_d = 1'b1;
        if (frame_start) restart_d = 1'b1;
        if (ack) begin
          rd_req_d = 1'b0;
          if (restart_q || frame_start) begin
            restart_now = 1'b1;
          end else if (k_q == K_LAST) begin
            k_d        = '0;
            row_base_d = row_base_q + ROW_STRIDE;
            line_d     = line_q + 10'd1;
            if (line_q == LINE_LAST) begin
              // Skip the gap cycle so frame_done coincides with the return to idle.
              state_d      = S_IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d = S_NEXT;
            end
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (frame_start) begin
          restart_now = 1'b1;
        end else if (k_q != '0) begin
          state_d   = S_REQ;
          rd_req_d  = 1'b1;
          rd_addr_d = burst_addr;
        end else begin
          state_d = S_WAIT_LINE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart_now) begin
      state_d    = S_WAIT_LINE;
      k_d        = '0;
      line_d     = '0;
      row_base_d = BASE;
      restart_d  = 1'b0;
    end
  end

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      line_q       <= '0;
      row_base_q   <= BASE;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      restart_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      line_q       <= line_d;
      row_base_q   <= row_base_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      restart_q    <= restart_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign x_cur      = x_cur_w;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
